// File: rtl/firebird7_in_gate2_secure_pkg.sv
// Shared definitions for the secure select TDR: FSM state codes, the
// layout of the captured status vector and the fail counter helpers.
package firebird7_in_gate2_secure_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'b00,
    ST_UNLOCKED = 2'b01,
    ST_BLOCKED  = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_e;

  localparam int FAIL_CNT_W = 2;

  // Bit positions of the status vector loaded on capture.
  localparam int CAP_SEL_BIT   = 0;
  localparam int CAP_STATE_LSB = 1;
  localparam int CAP_STATE_MSB = 2;
  localparam int CAP_FAIL_LSB  = 3;
  localparam int CAP_FAIL_MSB  = 4;

  localparam logic [FAIL_CNT_W-1:0] FAIL_ONE = 1;

  // Saturating increment: the counter never wraps past the limit.
  function automatic logic [FAIL_CNT_W-1:0] fail_inc(
    input logic [FAIL_CNT_W-1:0] cnt,
    input logic [FAIL_CNT_W-1:0] lim
  );
    if (cnt >= lim) return lim;
    return cnt + FAIL_ONE;
  endfunction

endpackage

// File: rtl/firebird7_in_gate2_secure_select_tdr.sv
// Key-protected IJTAG select register. A scanned-in key must match KEY
// before the select bit can reach the downstream secure scan mux; repeated
// wrong keys lock the register in BLOCKED until reset.
//
// Operation qualification: capture, shift and update act only while
// ijtag_sel is 1. When several enables are high in one cycle, update wins
// over capture, capture wins over shift, and only the winner takes effect.
// The shift register is left untouched by an update.
module firebird7_in_gate2_secure_select_tdr
  import firebird7_in_gate2_secure_pkg::*;
#(
  parameter int                    KEY_WIDTH = 8,
  parameter logic [KEY_WIDTH-1:0]  KEY       = 8'hA5,
  parameter int                    MAX_FAIL  = 3
) (
  input  logic ijtag_tck,
  input  logic ijtag_reset,
  input  logic ijtag_sel,
  input  logic ijtag_ce,
  input  logic ijtag_se,
  input  logic ijtag_ue,
  input  logic ijtag_si,
  output logic ijtag_so,
  output logic mux_select,
  output logic unlocked,
  output logic blocked
);

  localparam int SW = KEY_WIDTH + 1;
  localparam logic [FAIL_CNT_W-1:0] MAX_FAIL_C = FAIL_CNT_W'(MAX_FAIL);

  state_e                state_q, state_d;
  logic [SW-1:0]         sr_q, sr_d;
  logic [SW-1:0]         cap_vec;
  logic [FAIL_CNT_W-1:0] fail_q, fail_d;
  logic                  mux_q, mux_d;
  logic                  do_upd, do_cap, do_shf;
  logic                  key_match;

  assign do_upd    = ijtag_sel & ijtag_ue;
  assign do_cap    = ijtag_sel & ijtag_ce & ~ijtag_ue;
  assign do_shf    = ijtag_sel & ijtag_se & ~ijtag_ue & ~ijtag_ce;
  assign key_match = (sr_q[SW-1:1] == KEY);

  // Status vector presented to the shift register on capture.
  always_comb begin
    cap_vec = '0;
    cap_vec[CAP_SEL_BIT]                 = mux_q;
    cap_vec[CAP_STATE_MSB:CAP_STATE_LSB] = state_q;
    cap_vec[CAP_FAIL_MSB:CAP_FAIL_LSB]   = fail_q;
  end

  // Shift register next value: capture load or right shift.
  always_comb begin
    sr_d = sr_q;
    if (do_cap) begin
      sr_d = cap_vec;
    end else if (do_shf) begin
      sr_d = {ijtag_si, sr_q[SW-1:1]};
    end
  end

  // FSM state register.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q <= ST_LOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: shift register, fail counter and select.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sr_q   <= '0;
      fail_q <= '0;
      mux_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      fail_q <= fail_d;
      mux_q  <= mux_d;
    end
  end

  // FSM next state, fail counter and select, evaluated on update.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    mux_d   = mux_q;
    if (state_q == ST_ILLEGAL) begin
      // Unreachable code: recover to the safe, blocked state.
      state_d = ST_BLOCKED;
      mux_d   = 1'b0;
    end else if (do_upd) begin
      case (state_q)
        ST_LOCKED: begin
          if (key_match) begin
            state_d = ST_UNLOCKED;
            mux_d   = sr_q[0];
            fail_d  = '0;
          end else begin
            mux_d  = 1'b0;
            fail_d = fail_inc(fail_q, MAX_FAIL_C);
            if (fail_d == MAX_FAIL_C) state_d = ST_BLOCKED;
          end
        end
        ST_UNLOCKED: begin
          if (key_match) begin
            mux_d = sr_q[0];
          end else begin
            mux_d   = 1'b0;
            fail_d  = FAIL_ONE;
            state_d = (MAX_FAIL_C == FAIL_ONE) ? ST_BLOCKED : ST_LOCKED;
          end
        end
        default: begin
          // BLOCKED ignores updates; only reset leaves it.
          mux_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    ijtag_so   = sr_q[0];
    mux_select = mux_q;
    unlocked   = (state_q == ST_UNLOCKED);
    blocked    = (state_q == ST_BLOCKED);
  end

endmodule

// File: tb/tb_firebird7_in_gate2_secure_select_tdr.sv
// Directed bench for the secure select TDR: a table of key transactions
// with expected outputs and captured status, plus hand-written sequences
// for priority, select gating and reset abort.
module tb_firebird7_in_gate2_secure_select_tdr;

  logic ijtag_tck;
  logic ijtag_reset;
  logic ijtag_sel;
  logic ijtag_ce;
  logic ijtag_se;
  logic ijtag_ue;
  logic ijtag_si;
  logic ijtag_so;
  logic mux_select;
  logic unlocked;
  logic blocked;

  int n_cmp;
  int n_err;

  firebird7_in_gate2_secure_select_tdr dut (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .ijtag_sel   (ijtag_sel),
    .ijtag_ce    (ijtag_ce),
    .ijtag_se    (ijtag_se),
    .ijtag_ue    (ijtag_ue),
    .ijtag_si    (ijtag_si),
    .ijtag_so    (ijtag_so),
    .mux_select  (mux_select),
    .unlocked    (unlocked),
    .blocked     (blocked)
  );

  // Clock: posedge is the active edge; the bench drives and samples on negedge.
  initial ijtag_tck = 1'b0;
  always #5 ijtag_tck = ~ijtag_tck;

  typedef struct {
    logic       rst_first;
    logic [7:0] key;
    logic       req;
    logic       exp_mux;
    logic       exp_unl;
    logic       exp_blk;
    logic [8:0] exp_cap;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(negedge ijtag_tck);
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 9'h%03h, expected 9'h%03h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    ijtag_reset = 1'b0;
    ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
    ijtag_sel = 1'b1;
    tick();
    tick();
    ijtag_reset = 1'b1;
    tick();
  endtask

  // Shift 9 bits in, LSB first; returns the 9 bits seen on scan-out.
  task automatic shift_vec(input logic [8:0] v, output logic [8:0] out);
    for (int i = 0; i < 9; i++) begin
      ijtag_se = 1'b1;
      ijtag_si = v[i];
      out[i]   = ijtag_so;
      tick();
    end
    ijtag_se = 1'b0;
    ijtag_si = 1'b0;
  endtask

  task automatic do_update();
    ijtag_ue = 1'b1;
    tick();
    ijtag_ue = 1'b0;
  endtask

  task automatic read_cap(output logic [8:0] v);
    ijtag_ce = 1'b1;
    tick();
    ijtag_ce = 1'b0;
    shift_vec(9'h000, v);
  endtask

  initial begin
    logic [8:0] rd;
    n_cmp = 0;
    n_err = 0;
    ijtag_reset = 1'b0;
    ijtag_sel = 1'b0; ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;

    //            rst   key    req  mux  unl  blk  capture
    vecs[0]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 9'h008};
    vecs[1]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 9'h003};
    vecs[2]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 9'h002};
    vecs[3]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 9'h003};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 9'h008};
    vecs[5]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 9'h010};
    vecs[6]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 9'h003};
    vecs[7]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 9'h008};
    vecs[8]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 9'h010};
    vecs[9]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 9'h01C};
    vecs[10] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 9'h01C};

    // Reset state
    reset_dut();
    chk("rst_mux", 9'(mux_select), 9'h000);
    chk("rst_unl", 9'(unlocked), 9'h000);
    chk("rst_blk", 9'(blocked), 9'h000);
    chk("rst_so", 9'(ijtag_so), 9'h000);
    read_cap(rd);
    chk("rst_cap", rd, 9'h000);

    // Table of key transactions
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rst_first) reset_dut();
      shift_vec({vecs[i].key, vecs[i].req}, rd);
      do_update();
      chk($sformatf("v%0d_mux", i), 9'(mux_select), 9'(vecs[i].exp_mux));
      chk($sformatf("v%0d_unl", i), 9'(unlocked), 9'(vecs[i].exp_unl));
      chk($sformatf("v%0d_blk", i), 9'(blocked), 9'(vecs[i].exp_blk));
      read_cap(rd);
      chk($sformatf("v%0d_cap", i), rd, vecs[i].exp_cap);
    end

    // Priority: ce, se and ue together -> update only, no shift, no capture
    reset_dut();
    shift_vec(9'h14B, rd);
    ijtag_ce = 1'b1; ijtag_se = 1'b1; ijtag_ue = 1'b1; ijtag_si = 1'b1;
    tick();
    ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
    chk("prio_mux", 9'(mux_select), 9'h001);
    chk("prio_unl", 9'(unlocked), 9'h001);
    shift_vec(9'h000, rd);
    chk("prio_sr", rd, 9'h14B);

    // Select gating: nothing acts while ijtag_sel is 0
    ijtag_sel = 1'b0;
    ijtag_se = 1'b1; ijtag_si = 1'b1;
    tick(); tick(); tick();
    ijtag_se = 1'b0;
    ijtag_ue = 1'b1;
    tick();
    ijtag_ue = 1'b0;
    ijtag_ce = 1'b1;
    tick();
    ijtag_ce = 1'b0; ijtag_si = 1'b0;
    ijtag_sel = 1'b1;
    chk("gate_mux", 9'(mux_select), 9'h001);
    chk("gate_unl", 9'(unlocked), 9'h001);
    chk("gate_blk", 9'(blocked), 9'h000);
    shift_vec(9'h000, rd);
    chk("gate_sr", rd, 9'h000);

    // Reset abort after 4 of 9 shift bits
    reset_dut();
    shift_vec(9'h14B, rd);
    do_update();
    chk("abort_pre_mux", 9'(mux_select), 9'h001);
    for (int i = 0; i < 4; i++) begin
      ijtag_se = 1'b1;
      ijtag_si = (i % 2 == 0);
      tick();
    end
    #2 ijtag_reset = 1'b0;
    #1;
    chk("abort_mux", 9'(mux_select), 9'h000);
    chk("abort_unl", 9'(unlocked), 9'h000);
    chk("abort_so", 9'(ijtag_so), 9'h000);
    ijtag_se = 1'b0; ijtag_si = 1'b0;
    tick();
    ijtag_reset = 1'b1;
    tick();
    chk("abort_rel_mux", 9'(mux_select), 9'h000);
    chk("abort_rel_blk", 9'(blocked), 9'h000);
    read_cap(rd);
    chk("abort_cap", rd, 9'h000);
    do_update();
    read_cap(rd);
    chk("abort_upd_cap", rd, 9'h008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate2_secure_select_tdr.md
FIREBIRD7_IN_GATE2_SECURE_SELECT_TDR -- requirements
Module: firebird7_in_gate2_secure_select_tdr

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 8, meaning the width of the unlock key field in the shift register.
REQ-002 SHALL have parameter KEY, default 8'hA5, meaning the key value that unlocks the select bit.
REQ-003 SHALL have parameter MAX_FAIL, default 3, legal range 1..3, meaning the number of consecutive key mismatches that blocks the register.
REQ-004 SHALL have port ijtag_tck, input, 1 bit: the single clock; all state SHALL be updated on the rising edge.
REQ-005 SHALL have port ijtag_reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ijtag_sel, input, 1 bit: segment select; capture, shift and update act only while it is 1.
REQ-007 SHALL have port ijtag_ce, input, 1 bit: capture enable.
REQ-008 SHALL have port ijtag_se, input, 1 bit: shift enable.
REQ-009 SHALL have port ijtag_ue, input, 1 bit: update enable.
REQ-010 SHALL have port ijtag_si, input, 1 bit: scan-in.
REQ-011 SHALL have port ijtag_so, output, 1 bit: scan-out, equal to shift register bit 0 (combinational, no retiming).
REQ-012 SHALL have port mux_select, output, 1 bit: registered select driving the downstream secure scan mux.
REQ-013 SHALL have port unlocked, output, 1 bit: 1 when the FSM is in UNLOCKED.
REQ-014 SHALL have port blocked, output, 1 bit: 1 when the FSM is in BLOCKED.

Function
REQ-015 The shift register SHALL be SW = KEY_WIDTH+1 bits: bit 0 is the select request and bits [SW-1:1] are the key field.
REQ-016 On shift (sel & se), the register SHALL shift right: ijtag_si enters bit SW-1 and bit 0 is discarded.
REQ-017 On capture (sel & ce), the register SHALL load the status vector: bit 0 = mux_select, bits[2:1] = state code, bits[4:3] = fail_count, and all higher bits 0.
REQ-018 The state codes SHALL be LOCKED=2'b00, UNLOCKED=2'b01 and BLOCKED=2'b10; 2'b11 is illegal and SHALL recover to BLOCKED.
REQ-019 An update (sel & ue) SHALL evaluate in one cycle: match = (key field == KEY).
REQ-020 In LOCKED with match, the block SHALL go to UNLOCKED, set mux_select = bit 0 and set fail_count = 0.
REQ-021 In LOCKED with a mismatch, fail_count SHALL increment; if the new count equals MAX_FAIL, the block SHALL go to BLOCKED; mux_select stays 0.
REQ-022 In UNLOCKED with match, mux_select SHALL take bit 0 and the state SHALL remain UNLOCKED.
REQ-023 In UNLOCKED with a mismatch, the block SHALL go to LOCKED, force mux_select to 0 and set fail_count = 1; if MAX_FAIL = 1 it SHALL go to BLOCKED instead.
REQ-024 In BLOCKED, updates SHALL be ignored, mux_select SHALL be 0 and fail_count SHALL hold; only reset exits BLOCKED.
REQ-025 fail_count SHALL saturate at MAX_FAIL and never wrap.
REQ-026 If more than one of ce, se and ue is asserted in the same cycle, priority SHALL be update > capture > shift, and only the winning operation SHALL take effect.
REQ-027 mux_select, unlocked and blocked SHALL change only on an update cycle or on reset; they SHALL be valid the cycle after the update edge.
REQ-028 With ijtag_sel = 0, the shift register, FSM and outputs SHALL hold their values.

Reset
REQ-029 Asserting ijtag_reset low SHALL immediately clear the shift register, fail_count and mux_select, and force state = LOCKED.
REQ-030 After reset, ijtag_so = 0, mux_select = 0, unlocked = 0 and blocked = 0.
REQ-031 A reset asserted mid-shift or mid-update SHALL abort the operation, with no partial update applied after release.

Structure
REQ-032 Package firebird7_in_gate2_secure_pkg SHALL hold the state codes, the capture bit positions and the fail counter width (2).
REQ-033 The block SHALL be a single module with no sub-module; the key comparator and FSM are inline.

Verification
REQ-034 The bench SHALL check reset: reset low, then release -> mux_select = 0, unlocked = 0, blocked = 0, and a capture/shift of 9 bits reads 9'h000.
REQ-035 The bench SHALL check unlock: shift {8'hA5, 1'b1}, then update -> unlocked = 1 and mux_select = 1; a capture then reads bit 0 = 1, state = 01, fail_count = 00.
REQ-036 The bench SHALL check relock: from UNLOCKED, shift {8'h00, 1'b1}, then update -> mux_select = 0, unlocked = 0, fail_count = 1.
REQ-037 The bench SHALL check blocking: from reset, run 3 updates with key 8'h3C -> blocked = 1; a further update with 8'hA5 leaves mux_select = 0, and a capture reads state = 10, fail_count = 11.
REQ-038 The bench SHALL check priority: ce, se and ue all 1 with a valid key loaded -> the update applies, the register does not shift, and mux_select follows bit 0.
REQ-039 The bench SHALL check gating and reset abort: ijtag_sel = 0 with ue = 1 -> no change; reset asserted after 4 of 9 shift bits -> all state is cleared, and mux_select = 0 after release.
